// File: rtl/rifl_axis_frame_limiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rifl_axis_frame_limiter_if
// Brief   : AXI-Stream bundle (tdata/tkeep/tlast/tvalid/tready) for the limiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface rifl_axis_frame_limiter_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0]   tdata;
    logic [DWIDTH/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/rifl_axis_frame_limiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rifl_axis_frame_limiter
// Brief   : Caps AXI-Stream frames at MAX_BEATS beats (split or truncate), with a
//           registered output stage and skid buffer. Optional statistics counters
//           are enabled with RIFL_FRAME_LIMITER_STATS_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module rifl_axis_frame_limiter #(
    parameter int DWIDTH      = 32,
    parameter int MAX_BEATS   = 16,
    parameter int DROP_EXCESS = 0
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    rifl_axis_frame_limiter_if.slave   s_axis,
    rifl_axis_frame_limiter_if.master  m_axis,
    output logic                       trunc_pulse
`ifdef RIFL_FRAME_LIMITER_STATS_EN
    ,
    output logic [31:0]                frame_cnt,
    output logic [31:0]                trunc_cnt
`endif
);

    localparam int              c_CW    = $clog2(MAX_BEATS + 1);
    localparam int              c_KW    = DWIDTH / 8;
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(MAX_BEATS - 1);

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_beat_cnt;
    logic [c_CW-1:0]   w_beat_cnt_nxt;
    logic              w_trunc;
    logic              r_trunc_pulse;

    logic              r_main_valid;
    logic [DWIDTH-1:0] r_main_data;
    logic [c_KW-1:0]   r_main_keep;
    logic              r_main_last;
    logic              r_skid_valid;
    logic [DWIDTH-1:0] r_skid_data;
    logic [c_KW-1:0]   r_skid_keep;
    logic              r_skid_last;

    logic              w_accept;
    logic              w_fwd;
    logic              w_fwd_last;
    logic              w_out_xfer;

    // Ready depends only on registers; DROP swallows beats so it never stalls.
    assign s_axis.tready = (r_state == ST_DROP) | ~r_skid_valid;
    assign w_accept      = s_axis.tvalid & s_axis.tready;
    assign w_fwd         = w_accept & (r_state == ST_PASS);
    assign w_fwd_last    = s_axis.tlast | (r_beat_cnt == c_LIMIT);
    assign w_out_xfer    = r_main_valid & m_axis.tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_PASS;
            r_beat_cnt    <= '0;
            r_trunc_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_trunc_pulse <= w_trunc;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_trunc        = 1'b0;
        case (r_state)
            ST_PASS: begin
                if (w_fwd) begin
                    if (s_axis.tlast) begin
                        w_beat_cnt_nxt = '0;
                    end else if (r_beat_cnt == c_LIMIT) begin
                        w_beat_cnt_nxt = '0;
                        w_trunc        = 1'b1;
                        if (DROP_EXCESS != 0) begin
                            w_state_nxt = ST_DROP;
                        end
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + c_CW'(1);
                    end
                end
            end
            ST_DROP: begin
                if (w_accept && s_axis.tlast) begin
                    w_state_nxt = ST_PASS;
                end
            end
            default: begin
                w_state_nxt    = ST_PASS;
                w_beat_cnt_nxt = '0;
            end
        endcase
    end

    // Main refills from skid first so beat order is preserved after a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_keep  <= '0;
            r_main_last  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_keep  <= '0;
            r_skid_last  <= 1'b0;
        end else if (!r_main_valid || w_out_xfer) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_main_keep  <= r_skid_keep;
                r_main_last  <= r_skid_last;
                r_skid_valid <= 1'b0;
            end else if (w_fwd) begin
                r_main_valid <= 1'b1;
                r_main_data  <= s_axis.tdata;
                r_main_keep  <= s_axis.tkeep;
                r_main_last  <= w_fwd_last;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_fwd) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= s_axis.tdata;
            r_skid_keep  <= s_axis.tkeep;
            r_skid_last  <= w_fwd_last;
        end
    end

    assign m_axis.tvalid = r_main_valid;
    assign m_axis.tdata  = r_main_data;
    assign m_axis.tkeep  = r_main_keep;
    assign m_axis.tlast  = r_main_last;
    assign trunc_pulse   = r_trunc_pulse;

`ifdef RIFL_FRAME_LIMITER_STATS_EN
    logic [31:0] r_frame_cnt;
    logic [31:0] r_trunc_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_trunc_cnt <= '0;
        end else begin
            if (w_out_xfer && r_main_last && !(&r_frame_cnt)) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            if (w_trunc && !(&r_trunc_cnt)) begin
                r_trunc_cnt <= r_trunc_cnt + 32'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign trunc_cnt = r_trunc_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rifl_axis_frame_limiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_rifl_axis_frame_limiter
// Brief   : Frame-level model bench for the limiter; instance 0 splits, instance 1 drops.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rifl_axis_frame_limiter;

    localparam int c_DW = 32;
    localparam int c_KW = 4;
    localparam int c_MB = 4;

    typedef logic [c_DW+c_KW:0] beat_t;   // {last, keep, data}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rifl_axis_frame_limiter_if #(.DWIDTH(c_DW)) s_if0 ();
    rifl_axis_frame_limiter_if #(.DWIDTH(c_DW)) m_if0 ();
    rifl_axis_frame_limiter_if #(.DWIDTH(c_DW)) s_if1 ();
    rifl_axis_frame_limiter_if #(.DWIDTH(c_DW)) m_if1 ();

    logic [c_DW-1:0] in_data  [2];
    logic [c_KW-1:0] in_keep  [2];
    logic            in_last  [2];
    logic            in_valid [2];
    logic            in_ready [2];
    logic [c_DW-1:0] out_data [2];
    logic [c_KW-1:0] out_keep [2];
    logic            out_last [2];
    logic            out_valid[2];
    logic            trunc    [2];
    logic            out_ready;

    assign s_if0.tdata = in_data[0];  assign s_if1.tdata = in_data[1];
    assign s_if0.tkeep = in_keep[0];  assign s_if1.tkeep = in_keep[1];
    assign s_if0.tlast = in_last[0];  assign s_if1.tlast = in_last[1];
    assign s_if0.tvalid = in_valid[0]; assign s_if1.tvalid = in_valid[1];
    assign in_ready[0] = s_if0.tready; assign in_ready[1] = s_if1.tready;
    assign out_data[0] = m_if0.tdata;  assign out_data[1] = m_if1.tdata;
    assign out_keep[0] = m_if0.tkeep;  assign out_keep[1] = m_if1.tkeep;
    assign out_last[0] = m_if0.tlast;  assign out_last[1] = m_if1.tlast;
    assign out_valid[0] = m_if0.tvalid; assign out_valid[1] = m_if1.tvalid;
    assign m_if0.tready = out_ready;   assign m_if1.tready = out_ready;

    rifl_axis_frame_limiter #(.DWIDTH(c_DW), .MAX_BEATS(c_MB), .DROP_EXCESS(0)) u_dut_split (
        .clk(clk), .rst_n(rst_n), .s_axis(s_if0), .m_axis(m_if0), .trunc_pulse(trunc[0]));
    rifl_axis_frame_limiter #(.DWIDTH(c_DW), .MAX_BEATS(c_MB), .DROP_EXCESS(1)) u_dut_drop (
        .clk(clk), .rst_n(rst_n), .s_axis(s_if1), .m_axis(m_if1), .trunc_pulse(trunc[1]));

    beat_t q0[$];
    beat_t q1[$];
    int    tests = 0;
    int    fails = 0;
    int    exp_trunc[2];
    int    obs_trunc[2];
    int    obs_beats[2];
    int    obs_lasts[2];
    bit    chk_en  = 1'b0;
    int    bp_mode = 0;   // 0: ready high, 1: 1,0,0,1 pattern, 2: ready low

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] base, input int i, input logic last);
        logic [c_KW-1:0] kp;
        logic [7:0]      idx;
        kp  = c_KW'(i * 5 + 3);
        idx = 8'(i);
        return {last, kp, 16'hCAFE, base, idx};
    endfunction

    function automatic void push(input int k, input beat_t b);
        if (k == 0) q0.push_back(b); else q1.push_back(b);
    endfunction

    // Output of one input frame, derived from the frame length alone.
    function automatic void model_frame(input int k, input int len, input logic [7:0] base);
        int n;
        if (k == 0) begin
            for (int i = 0; i < len; i++)
                push(k, mk(base, i, (i == len - 1) || (i % c_MB == c_MB - 1)));
            exp_trunc[k] += (len - 1) / c_MB;
        end else begin
            n = (len < c_MB) ? len : c_MB;
            for (int i = 0; i < n; i++) push(k, mk(base, i, i == n - 1));
            if (len > c_MB) exp_trunc[k] += 1;
        end
    endfunction

    task automatic send_frame(input int k, input int len, input logic [7:0] base,
                              input bit use_model, input bit lat_chk);
        beat_t b;
        int    w;
        if (use_model) model_frame(k, len, base);
        for (int i = 0; i < len; i++) begin
            b = mk(base, i, i == len - 1);
            in_data[k]  = b[c_DW-1:0];
            in_keep[k]  = b[c_DW+c_KW-1:c_DW];
            in_last[k]  = b[c_DW+c_KW];
            in_valid[k] = 1'b1;
            @(negedge clk);
            w = 0;
            while (!in_ready[k] && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (w >= 100) begin
                tests++;
                fails++;
                $display("FAIL in_ready_timeout: inst %0d got ready=0 required 1", k);
                in_valid[k] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (lat_chk && i == 0)
                check("latency", {31'd0, out_valid[k], out_data[k]}, {31'd0, 1'b1, 16'hCAFE, base, 8'h00});
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++) begin
            exp_trunc[k] = 0; obs_trunc[k] = 0; obs_beats[k] = 0; obs_lasts[k] = 0;
        end
    endtask

    task automatic end_scn(input int k, input string name, input int lb, input int ll, input int lt);
        int w;
        w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 300) begin
            @(posedge clk);
            w++;
        end
        repeat (6) @(posedge clk);
        #1;
        check({name, "_q_empty"}, 64'(q0.size() + q1.size()), 64'd0);
        check({name, "_trunc_model"}, 64'(obs_trunc[k]), 64'(exp_trunc[k]));
        check({name, "_beats"}, 64'(obs_beats[k]), 64'(lb));
        check({name, "_lasts"}, 64'(obs_lasts[k]), 64'(ll));
        check({name, "_trunc"}, 64'(obs_trunc[k]), 64'(lt));
        check({name, "_other_idle"}, 64'(obs_beats[1-k]), 64'd0);
        clear_counts();
    endtask

    // Per-cycle compare against the model queues.
    initial begin
        beat_t prev[2];
        bit    stall[2];
        beat_t got;
        beat_t e;
        stall[0] = 1'b0; stall[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!chk_en || !rst_n) begin
                    stall[k] = 1'b0;
                end else begin
                    got = {out_last[k], out_keep[k], out_data[k]};
                    if (stall[k])
                        check("stall_hold", {26'd0, out_valid[k], got}, {26'd0, 1'b1, prev[k]});
                    if (out_valid[k] && out_ready) begin
                        obs_beats[k]++;
                        if (out_last[k]) obs_lasts[k]++;
                        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL extra_beat: inst %0d got %0h required none", k, got);
                        end else begin
                            e = (k == 0) ? q0.pop_front() : q1.pop_front();
                            check(k == 0 ? "beat_split" : "beat_drop", 64'(got), 64'(e));
                        end
                    end
                    stall[k] = out_valid[k] && !out_ready;
                    prev[k]  = got;
                    if (trunc[k]) obs_trunc[k]++;
                end
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            in_data[k] = '0; in_keep[k] = '0; in_last[k] = 1'b0; in_valid[k] = 1'b0;
        end
        clear_counts();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("rst_tvalid", 64'(out_valid[k]), 64'd0);
            check("rst_tready", 64'(in_ready[k]), 64'd1);
            check("rst_outregs", {27'd0, out_last[k], out_keep[k], out_data[k]}, 64'd0);
            check("rst_trunc", 64'(trunc[k]), 64'd0);
        end
        chk_en = 1'b1;

        send_frame(0, 3, 8'h10, 1'b1, 1'b1);
        end_scn(0, "short", 3, 1, 0);
        send_frame(0, 10, 8'h20, 1'b1, 1'b0);
        end_scn(0, "split10", 10, 3, 2);
        send_frame(1, 7, 8'h30, 1'b1, 1'b1);
        send_frame(1, 2, 8'h31, 1'b1, 1'b0);
        end_scn(1, "drop7", 6, 2, 1);
        send_frame(1, 10, 8'h32, 1'b1, 1'b0);
        end_scn(1, "drop10", 4, 1, 1);
        send_frame(0, 4, 8'h40, 1'b1, 1'b0);
        send_frame(0, 1, 8'h41, 1'b1, 1'b0);
        end_scn(0, "exact4", 5, 2, 0);
        send_frame(1, 4, 8'h42, 1'b1, 1'b0);
        send_frame(1, 2, 8'h43, 1'b1, 1'b0);
        end_scn(1, "exact4d", 6, 2, 0);
        send_frame(0, 5, 8'h50, 1'b1, 1'b0);
        end_scn(0, "onebeat", 5, 2, 1);

        bp_mode = 1;
        send_frame(0, 3, 8'h60, 1'b1, 1'b0);
        send_frame(0, 10, 8'h61, 1'b1, 1'b0);
        send_frame(0, 4, 8'h62, 1'b1, 1'b0);
        send_frame(0, 1, 8'h63, 1'b1, 1'b0);
        end_scn(0, "bp_split", 18, 6, 2);
        send_frame(1, 3, 8'h70, 1'b1, 1'b0);
        send_frame(1, 10, 8'h71, 1'b1, 1'b0);
        send_frame(1, 4, 8'h72, 1'b1, 1'b0);
        send_frame(1, 1, 8'h73, 1'b1, 1'b0);
        end_scn(1, "bp_drop", 12, 4, 1);

        bp_mode = 2;
        @(posedge clk);
        #1;
        send_frame(0, 2, 8'h80, 1'b0, 1'b0);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_tvalid", 64'(out_valid[0]), 64'd0);
        check("midrst_tready", 64'(in_ready[0]), 64'd1);
        check("midrst_trunc", 64'(trunc[0]), 64'd0);
        bp_mode = 0;
        @(posedge clk);
        #1;
        clear_counts();
        chk_en = 1'b1;
        send_frame(0, 6, 8'h90, 1'b1, 1'b1);
        end_scn(0, "after_rst", 6, 2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rifl_axis_frame_limiter.md
Name: rifl_axis_frame_limiter

Overview:
- Sits directly downstream of the team's AXI-Stream sync FIFO.
- Consumes its m_axis stream and enforces a maximum frame length of MAX_BEATS beats before the framing/CRC stage.
- Frames longer than the limit get a forced tlast. Depending on DROP_EXCESS, the remainder is either discarded or emitted as follow-on frames.
- Output is fully registered with a skid buffer, so s_axis_tready carries no combinational path from m_axis_tready.

Parameters:
- DWIDTH, 32, tdata width in bits; multiple of 8; tkeep is DWIDTH/8.
- MAX_BEATS, 16, maximum beats per output frame; legal range 2..65535.
- DROP_EXCESS, 0, 0 = split long frames into MAX_BEATS chunks; 1 = truncate and discard beats beyond MAX_BEATS up to the input tlast.

Ports:
- clk, input, 1, single clock domain.
- rst_n, input, 1, synchronous active-low reset.
- s_axis_tdata, input, DWIDTH, input data.
- s_axis_tkeep, input, DWIDTH/8, input byte enables.
- s_axis_tlast, input, 1, input end of frame.
- s_axis_tvalid, input, 1, input valid.
- s_axis_tready, output, 1, input ready.
- m_axis_tdata, output, DWIDTH, output data.
- m_axis_tkeep, output, DWIDTH/8, output byte enables.
- m_axis_tlast, output, 1, output end of frame (original or forced).
- m_axis_tvalid, output, 1, output valid.
- m_axis_tready, input, 1, output ready.
- trunc_pulse, output, 1, one-cycle pulse when a forced tlast is accepted at the input side.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. Every register clears on the rising edge of clk when rst_n=0.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, trunc_pulse=0, s_axis_tready=1 on the first cycle after reset. State=PASS, beat_cnt=0, skid empty.
- Reset mid-frame discards any partial frame with no flush. The next accepted beat starts a new frame.
- Handshake:
  - Input beat accepted when s_axis_tvalid & s_axis_tready. Output beat transferred when m_axis_tvalid & m_axis_tready.
  - Output data is stable while m_axis_tvalid=1 and m_axis_tready=0.
- Output stage:
  - Main output register plus one skid register; s_axis_tready = ~skid_valid (registered).
  - Latency is 1 cycle from input accept to m_axis_tvalid when the output is empty.
  - Throughput is 1 beat/cycle with m_axis_tready held high.
  - When the main register is stalled and a beat is accepted, that beat goes to skid. The skid drains into main on the next output transfer.
- beat_cnt is $clog2(MAX_BEATS+1) bits and counts beats accepted in the current output frame.
- State PASS:
  - Each accepted beat is forwarded and beat_cnt increments.
  - If s_axis_tlast=1: forward tlast=1, beat_cnt<=0.
  - Else if beat_cnt==MAX_BEATS-1 (limit reached): forward the beat with tlast=1 and pulse trunc_pulse, then:
    - DROP_EXCESS=0: stay in PASS, beat_cnt<=0; following beats form a new frame.
    - DROP_EXCESS=1: go to DROP, beat_cnt<=0.
- State DROP:
  - s_axis_tready is forced to 1 regardless of skid state. Accepted beats are discarded and nothing is written to the output.
  - The beat with s_axis_tlast=1 is also discarded, then state returns to PASS.
- Simultaneous events:
  - Input tlast on exactly beat MAX_BEATS is a natural end: no trunc_pulse, no DROP.
  - In DROP_EXCESS=0, a split chunk followed by an input tlast on the very next beat yields a 1-beat frame.
- tkeep is passed unmodified, including on forced-tlast beats.

Optional Feature:
- Macro: RIFL_FRAME_LIMITER_STATS_EN.
- When defined, adds two outputs, each saturating at all-ones and cleared by reset:
  - frame_cnt, 32, counts output beats transferred with m_axis_tlast=1.
  - trunc_cnt, 32, counts trunc_pulse events.
- When undefined, neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- MAX_BEATS=4, DROP_EXCESS=0, m_axis_tready=1, 3-beat frame D0..D2 with tlast on D2 -> output D0..D2 at 1-cycle latency, tlast only on D2, trunc_pulse never asserted.
- MAX_BEATS=4, DROP_EXCESS=0, 10-beat frame D0..D9 -> frames D0-D3 and D4-D7 with forced tlast on D3 and D7, then D8-D9 with original tlast; trunc_pulse asserted twice.
- MAX_BEATS=4, DROP_EXCESS=1, 7-beat frame D0..D6 followed by 2-beat frame E0..E1 -> output D0-D3 (tlast on D3), D4-D6 consumed with s_axis_tready=1 and no output, then E0-E1 emitted; one trunc_pulse.
- MAX_BEATS=4, 4-beat frame with tlast on beat 4 -> single 4-beat frame, no trunc_pulse, state stays PASS.
- Backpressure: continuous input, m_axis_tready toggles 1,0,0,1 repeating -> no beat lost or duplicated; s_axis_tready deasserts only while skid is full; data is stable during stalls.
- Reset: rst_n=0 for 1 cycle after beat 2 of a 6-beat frame -> m_axis_tvalid=0 next cycle, beat_cnt=0; the next input frame is counted from beat 1.
